// File: rtl/relu_stream.sv
// Multi-lane streaming activation unit: bypass / ReLU / leaky / clamped ReLU over a
// two-stage valid/ready pipeline, with a per-frame count of zero output elements.
module relu_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    mode,
  input  logic [DATA_WIDTH-1:0]         clamp_max,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic                          out_last,
  output logic [CNT_WIDTH-1:0]          frame_zero_count,
  output logic                          frame_done
);

  localparam int unsigned BUS_W = LANES * DATA_WIDTH;
  localparam int unsigned ZW    = $clog2(LANES + 1);

  logic                   s1_valid;
  logic [BUS_W-1:0]       s1_data;
  logic                   s1_last;
  logic [1:0]             s1_mode;
  logic [DATA_WIDTH-2:0]  s1_clamp;
  logic [BUS_W-1:0]       result;
  logic                   s1_move;
  logic                   out_fire;
  logic [ZW-1:0]          beat_zeros;
  logic [CNT_WIDTH-1:0]   zero_acc;
  logic [CNT_WIDTH:0]     acc_sum;
  logic [CNT_WIDTH-1:0]   acc_sat;
  logic                   clamp_msb_unused;

  // The clamp bound is always non-negative, so its sign bit carries no information.
  assign clamp_msb_unused = clamp_max[DATA_WIDTH-1];

  function automatic logic [DATA_WIDTH-1:0] activate(
    input logic [DATA_WIDTH-1:0] x_raw,
    input logic [1:0]            m,
    input logic [DATA_WIDTH-2:0] cm
  );
    logic signed [DATA_WIDTH-1:0] x;
    logic signed [DATA_WIDTH-1:0] lim;
    logic signed [DATA_WIDTH-1:0] y;
    logic                         neg;
    logic                         nonpos;
    x      = x_raw;
    lim    = {1'b0, cm};
    neg    = x[DATA_WIDTH-1];
    nonpos = neg || (x == '0);
    case (m)
      2'd0:    y = x;
      2'd1:    y = nonpos ? '0 : x;
      2'd2:    y = neg ? (x >>> LEAK_SHIFT) : x;
      default: y = nonpos ? '0 : ((x > lim) ? lim : x);
    endcase
    return y;
  endfunction

  assign s1_move  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_move;
  assign out_fire = out_valid && out_ready;

  // Stage-1 contents drive the activation; the result is captured by stage 2.
  always_comb begin
    result = '0;
    for (int i = 0; i < LANES; i++) begin
      result[i*DATA_WIDTH +: DATA_WIDTH] =
        activate(s1_data[i*DATA_WIDTH +: DATA_WIDTH], s1_mode, s1_clamp);
    end
  end

  // Zero lanes in the beat currently presented downstream, plus saturating accumulation.
  always_comb begin
    beat_zeros = '0;
    for (int i = 0; i < LANES; i++) begin
      if (out_data[i*DATA_WIDTH +: DATA_WIDTH] == '0) begin
        beat_zeros = beat_zeros + ZW'(1);
      end
    end
    acc_sum = {1'b0, zero_acc} + (CNT_WIDTH+1)'(beat_zeros);
    acc_sat = acc_sum[CNT_WIDTH] ? '1 : acc_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid         <= 1'b0;
      s1_data          <= '0;
      s1_last          <= 1'b0;
      s1_mode          <= 2'd0;
      s1_clamp         <= '0;
      out_valid        <= 1'b0;
      out_data         <= '0;
      out_last         <= 1'b0;
      zero_acc         <= '0;
      frame_zero_count <= '0;
      frame_done       <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data  <= in_data;
          s1_last  <= in_last;
          s1_mode  <= mode;
          s1_clamp <= clamp_max[DATA_WIDTH-2:0];
        end
      end
      if (s1_move) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= result;
          out_last <= s1_last;
        end
      end
      frame_done <= 1'b0;
      if (out_fire) begin
        if (out_last) begin
          frame_zero_count <= acc_sat;
          frame_done       <= 1'b1;
          zero_acc         <= '0;
        end else begin
          zero_acc <= acc_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_stream.sv
// Directed bench for relu_stream: activation modes, mode isolation in flight,
// backpressure, frame zero statistic and mid-frame reset.
module tb_relu_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned LN = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      mode;
  logic [DW-1:0]   clamp_max;
  logic            in_valid;
  logic            in_ready;
  logic [LN*DW-1:0] in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [LN*DW-1:0] out_data;
  logic            out_last;
  logic [15:0]     frame_zero_count;
  logic            frame_done;

  int checks   = 0;
  int failures = 0;

  relu_stream #(.DATA_WIDTH(8), .LANES(4), .LEAK_SHIFT(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clamp_max(clamp_max),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_zero_count(frame_zero_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] m, input logic [7:0] cm,
                       input logic l);
    in_valid  = 1'b1;
    in_data   = d;
    mode      = m;
    clamp_max = cm;
    in_last   = l;
  endtask

  // One single-beat frame through an idle, unstalled pipe.
  task automatic run1(input string tag, input logic [31:0] d, input logic [1:0] m,
                      input logic [7:0] cm, input logic [31:0] exp, input int expz);
    drive(d, m, cm, 1'b1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_olast"}, 32'(out_last), 32'd1);
    tick();
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    chk({tag, "_fzc"}, 32'(frame_zero_count), 32'(expz));
    chk({tag, "_fdone"}, 32'(frame_done), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_q [$];
    int          sent;
    int          rcv;
    logic        held;
    logic [31:0] held_data;
    logic        saw_stall;

    rst_n = 1'b0; mode = 2'd0; clamp_max = '0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_fzc", 32'(frame_zero_count), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Activation modes, one beat each, each its own frame.
    run1("relu",    pk(-128, -1, 0, 127),   2'd1, 8'd0,  pk(0, 0, 0, 127),     3);
    run1("leaky",   pk(-128, -8, -1, 5),    2'd2, 8'd0,  pk(-16, -1, -1, 5),   0);
    run1("bypass",  pk(-128, -8, -1, 5),    2'd0, 8'd0,  pk(-128, -8, -1, 5),  0);
    run1("clamp6",  pk(10, 6, 3, -4),       2'd3, 8'd6,  pk(6, 6, 3, 0),       1);
    run1("clampff", pk(127, -128, 100, 0),  2'd3, 8'hFF, pk(127, 0, 100, 0),   2);
    run1("leaky2",  pk(0, -9, -16, -127),   2'd2, 8'd0,  pk(0, -2, -2, -16),   1);
    chk("fdone_pulse", 32'(frame_done), 32'd1);
    tick();
    chk("fdone_clear", 32'(frame_done), 32'd0);

    // Mode switch on the very next beat must not touch the beat in flight.
    drive(pk(10, 6, 3, -4), 2'd3, 8'd6, 1'b0);
    tick();
    drive(pk(10, 6, 3, -4), 2'd1, 8'd6, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("switch_b1", out_data, pk(6, 6, 3, 0));
    tick();
    chk("switch_b2", out_data, pk(10, 6, 3, 0));
    chk("switch_b2_valid", 32'(out_valid), 32'd1);
    tick();
    chk("switch_fzc", 32'(frame_zero_count), 32'd2);
    chk("switch_fdone", 32'(frame_done), 32'd1);
    tick();

    // 8 back-to-back beats, out_ready low for cycles 3..6.
    sent = 0; rcv = 0; held = 1'b0; held_data = '0; saw_stall = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back(pk(k + 1, k + 2, 0, 100 - k));
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 8) drive(pk(sent + 1, sent + 2, -(sent + 3), 100 - sent), 2'd1, 8'd0, sent == 7);
      else in_valid = 1'b0;
      #1;
      if (held) chk("stall_stable", out_data, held_data);
      if (!in_ready) saw_stall = 1'b1;
      held = out_valid && !out_ready;
      held_data = out_data;
      if (out_valid && out_ready) begin
        chk($sformatf("stream_beat%0d", rcv), out_data, exp_q[rcv]);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 32'(rcv), 32'd8);
    chk("stream_in_ready_fell", 32'(saw_stall), 32'd1);
    chk("stream_fzc", 32'(frame_zero_count), 32'd8);
    chk("stream_fdone", 32'(frame_done), 32'd1);
    tick();

    // 3-beat frame with 1, 4 and 2 zero lanes.
    drive(pk(1, 2, 3, 0), 2'd1, 8'd0, 1'b0);
    tick();
    drive(pk(-1, 0, -5, -128), 2'd1, 8'd0, 1'b0);
    tick();
    drive(pk(0, -3, 7, 9), 2'd1, 8'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("frame_no_early_done", 32'(frame_done), 32'd0);
    tick();
    chk("frame_fzc", 32'(frame_zero_count), 32'd7);
    chk("frame_fdone", 32'(frame_done), 32'd1);
    tick();
    chk("frame_fdone_once", 32'(frame_done), 32'd0);
    run1("next_frame", pk(0, 0, 1, 1), 2'd1, 8'd0, pk(0, 0, 1, 1), 2);

    // Mid-frame reset with a partial count and two beats in flight.
    drive(pk(0, 0, 0, 0), 2'd1, 8'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    out_ready = 1'b0;
    drive(pk(0, 0, 0, 0), 2'd1, 8'd0, 1'b0);
    tick();
    drive(pk(-5, 0, 0, 0), 2'd1, 8'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_fzc", 32'(frame_zero_count), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    tick();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_empty", 32'(out_valid), 32'd0);
    run1("post_rst", pk(0, 1, 1, 1), 2'd1, 8'd0, pk(0, 1, 1, 1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
